// File: rtl/lsu_7seg_scan_pkg.sv
// Shared types and constants for the LSU 7-segment display path.
package lsu_pkg;

   localparam logic [6:0] SEG_OFF    = 7'h7F;
   localparam int         NUM_DIGITS = 4;
   localparam int         IDX_W      = 2;

   typedef enum logic {
      PH_BLANK,
      PH_SHOW
   } phase_e;

   // Active-low one-hot digit enable for the given digit index.
   function automatic logic [NUM_DIGITS-1:0] dig_sel_n(input logic [IDX_W-1:0] idx);
      return ~(NUM_DIGITS'(1) << idx);
   endfunction

endpackage

// File: rtl/lsu_scan_counter.sv
// Slot counter (0..DWELL-1) and digit index (0..3) with synchronous clear.
module lsu_scan_counter
   import lsu_pkg::*;
#(
   parameter int DWELL = 8,
   parameter int CW    = $clog2(DWELL)
) (
   input  logic             clk_i,
   input  logic             clr_i,
   output logic [CW-1:0]    cnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             wrap_o,
   output logic             frame_start_o
);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   assign wrap_o        = (cnt_q == CW'(DWELL - 1));
   assign frame_start_o = (cnt_q == '0) && (idx_q == '0);
   assign cnt_o         = cnt_q;
   assign idx_o         = idx_q;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
      if (wrap_o) begin
         cnt_d = '0;
         idx_d = idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/lsu_7seg_scan.sv
// Time-multiplexed 7-segment scan driver: per-frame shadow capture, blank/show phases.
// state    | meaning
// PH_BLANK | anti-ghosting interval at slot start, all outputs dark
// PH_SHOW  | current digit driven (unless masked) until slot end
module lsu_7seg_scan
   import lsu_pkg::*;
#(
   parameter int DWELL = 50000,
   parameter int BLANK = 500
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_en,
   input  logic [6:0]            i_7seg0,
   input  logic [6:0]            i_7seg1,
   input  logic [6:0]            i_7seg2,
   input  logic [6:0]            i_7seg3,
   input  logic [NUM_DIGITS-1:0] i_dp,
   input  logic [NUM_DIGITS-1:0] i_blank_mask,
   output logic [6:0]            o_seg,
   output logic                  o_dp,
   output logic [NUM_DIGITS-1:0] o_dig,
   output logic                  o_frame
);

   localparam int CW = $clog2(DWELL);

   if ((DWELL < 2) || (DWELL > 65535) || (BLANK < 1) || (BLANK > DWELL - 1)) begin : g_bad_param
      $error("lsu_7seg_scan: DWELL/BLANK out of legal range");
   end

   logic [CW-1:0]    cnt;
   logic [IDX_W-1:0] idx;
   logic             wrap, frame_start;

   lsu_scan_counter #(.DWELL(DWELL), .CW(CW)) u_cnt (
      .clk_i         (i_clk),
      .clr_i         (i_reset | ~i_en),
      .cnt_o         (cnt),
      .idx_o         (idx),
      .wrap_o        (wrap),
      .frame_start_o (frame_start)
   );

   phase_e                          phase_q;
   logic [NUM_DIGITS-1:0][6:0]      code_q;
   logic [NUM_DIGITS-1:0]           dp_q, mask_q;
   logic [6:0]                      seg_q, seg_d;
   logic [NUM_DIGITS-1:0]           dig_q, dig_d;
   logic                            dp_out_q, dp_out_d;
   logic                            frame_q;

   always_comb begin
      seg_d    = SEG_OFF;
      dig_d    = '1;
      dp_out_d = 1'b1;
      if ((phase_q == PH_SHOW) && !mask_q[idx]) begin
         seg_d    = code_q[idx];
         dig_d    = dig_sel_n(idx);
         dp_out_d = ~dp_q[idx];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         phase_q  <= PH_BLANK;
         code_q   <= {NUM_DIGITS{SEG_OFF}};
         dp_q     <= '0;
         mask_q   <= '1;
         seg_q    <= SEG_OFF;
         dig_q    <= '1;
         dp_out_q <= 1'b1;
         frame_q  <= 1'b0;
      end else if (!i_en) begin
         // Shadow deliberately holds so re-enable shows fresh capture only.
         phase_q  <= PH_BLANK;
         seg_q    <= SEG_OFF;
         dig_q    <= '1;
         dp_out_q <= 1'b1;
         frame_q  <= 1'b0;
      end else begin
         if (frame_start) begin
            code_q <= {i_7seg3, i_7seg2, i_7seg1, i_7seg0};
            dp_q   <= i_dp;
            mask_q <= i_blank_mask;
         end
         case (phase_q)
            PH_BLANK: if (cnt == CW'(BLANK - 1)) phase_q <= PH_SHOW;
            PH_SHOW:  if (wrap) phase_q <= PH_BLANK;
            default:  phase_q <= PH_BLANK;
         endcase
         seg_q    <= seg_d;
         dig_q    <= dig_d;
         dp_out_q <= dp_out_d;
         frame_q  <= wrap && (idx == IDX_W'(NUM_DIGITS - 1));
      end
   end

   assign o_seg   = seg_q;
   assign o_dig   = dig_q;
   assign o_dp    = dp_out_q;
   assign o_frame = frame_q;

endmodule

// File: tb/tb_lsu_7seg_scan.sv
// Bench for lsu_7seg_scan (DWELL=8, BLANK=2): frame-position reference model plus cycle tables.
module tb_lsu_7seg_scan;

   localparam int DW = 8;
   localparam int BL = 2;
   localparam int FR = 4 * DW;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b1;
   logic [6:0] s0 = 7'h7F, s1 = 7'h7F, s2 = 7'h7F, s3 = 7'h7F;
   logic [3:0] dp = 4'h0, mask = 4'h0;
   logic [6:0] o_seg;
   logic       o_dp;
   logic [3:0] o_dig;
   logic       o_frame;

   lsu_7seg_scan #(.DWELL(DW), .BLANK(BL)) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_en         (en),
      .i_7seg0      (s0),
      .i_7seg1      (s1),
      .i_7seg2      (s2),
      .i_7seg3      (s3),
      .i_dp         (dp),
      .i_blank_mask (mask),
      .o_seg        (o_seg),
      .o_dp         (o_dp),
      .o_dig        (o_dig),
      .o_frame      (o_frame)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ocyc   = 0;

   // Reference model: position inside the frame plus the captured shadow.
   int         m_pos = 0;
   logic [6:0] m_code [4];
   logic [3:0] m_dp = 4'h0, m_mask = 4'hF;
   logic [6:0] e_seg;
   logic [3:0] e_dig;
   logic       e_dp, e_frame;

   logic [6:0] obs_seg   [64];
   logic [3:0] obs_dig   [64];
   logic       obs_dp    [64];
   logic       obs_frame [64];

   typedef struct {
      int         sc;
      int         cyc;
      logic [3:0] dig;
      logic [6:0] seg;
      logic       dp;
      logic       frame;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input int sc, input int cyc, input logic [3:0] dig,
                      input logic [6:0] seg, input logic dpv, input logic fr);
      vec_t v;
      v.sc = sc; v.cyc = cyc; v.dig = dig; v.seg = seg; v.dp = dpv; v.frame = fr;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @t=%0t ocyc=%0d: got 0x%0h expected 0x%0h", name, $time, ocyc, act, exp);
      end
   endtask

   task automatic model_edge();
      int d, s;
      logic lit;
      e_seg = 7'h7F; e_dig = 4'hF; e_dp = 1'b1; e_frame = 1'b0;
      if (reset) begin
         m_pos = 0;
         for (int i = 0; i < 4; i++) m_code[i] = 7'h7F;
         m_dp = 4'h0;
         m_mask = 4'hF;
      end else if (!en) begin
         m_pos = 0;
      end else begin
         if (m_pos == 0) begin
            m_code[0] = s0; m_code[1] = s1; m_code[2] = s2; m_code[3] = s3;
            m_dp = dp;
            m_mask = mask;
         end
         d = m_pos / DW;
         s = m_pos % DW;
         lit = (s >= BL) && !m_mask[d];
         if (lit) begin
            e_dig = 4'hF ^ (4'h1 << d);
            e_seg = m_code[d];
            e_dp  = ~m_dp[d];
         end
         e_frame = (m_pos == FR - 1);
         m_pos = (m_pos + 1) % FR;
      end
   endtask

   task automatic tick();
      int lows;
      @(posedge clk);
      model_edge();
      #1;
      ocyc++;
      chk("model_dig", int'(o_dig), int'(e_dig));
      chk("model_seg", int'(o_seg), int'(e_seg));
      chk("model_dp", int'(o_dp), int'(e_dp));
      chk("model_frame", int'(o_frame), int'(e_frame));
      lows = $countones(~o_dig);
      checks++;
      if (lows > 1) begin
         errors++;
         $display("FAIL onehot ocyc=%0d: o_dig=0x%0h has %0d low bits, at most 1 allowed", ocyc, o_dig, lows);
      end
      if (ocyc < 64) begin
         obs_seg[ocyc] = o_seg; obs_dig[ocyc] = o_dig;
         obs_dp[ocyc] = o_dp;   obs_frame[ocyc] = o_frame;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      ocyc = 0;
   endtask

   task automatic check_tbl(input int sc);
      foreach (tbl[i]) begin
         if (tbl[i].sc == sc) begin
            $display("scenario %0d cycle %0d", sc, tbl[i].cyc);
            chk("tbl_dig", int'(obs_dig[tbl[i].cyc]), int'(tbl[i].dig));
            chk("tbl_seg", int'(obs_seg[tbl[i].cyc]), int'(tbl[i].seg));
            chk("tbl_dp", int'(obs_dp[tbl[i].cyc]), int'(tbl[i].dp));
            chk("tbl_frame", int'(obs_frame[tbl[i].cyc]), int'(tbl[i].frame));
         end
      end
   endtask

   task automatic std_inputs();
      s0 = 7'h40; s1 = 7'h79; s2 = 7'h24; s3 = 7'h30;
      dp = 4'h0; mask = 4'h0; en = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) m_code[i] = 7'h7F;

      // Scenario 1+2: basic scan, mid-frame change of digit 0.
      add(1, 1, 4'hF, 7'h7F, 1, 0);  add(1, 2, 4'hF, 7'h7F, 1, 0);
      add(1, 3, 4'hE, 7'h40, 1, 0);  add(1, 8, 4'hE, 7'h40, 1, 0);
      add(1, 9, 4'hF, 7'h7F, 1, 0);  add(1, 10, 4'hF, 7'h7F, 1, 0);
      add(1, 11, 4'hD, 7'h79, 1, 0); add(1, 16, 4'hD, 7'h79, 1, 0);
      add(1, 17, 4'hF, 7'h7F, 1, 0); add(1, 19, 4'hB, 7'h24, 1, 0);
      add(1, 24, 4'hB, 7'h24, 1, 0); add(1, 25, 4'hF, 7'h7F, 1, 0);
      add(1, 27, 4'h7, 7'h30, 1, 0); add(1, 31, 4'h7, 7'h30, 1, 0);
      add(1, 32, 4'h7, 7'h30, 1, 1); add(1, 33, 4'hF, 7'h7F, 1, 0);
      add(1, 34, 4'hF, 7'h7F, 1, 0); add(1, 35, 4'hE, 7'h00, 1, 0);
      add(1, 40, 4'hE, 7'h00, 1, 0); add(1, 41, 4'hF, 7'h7F, 1, 0);
      // Scenario 3: mask digit 2, dp on digit 0.
      add(3, 3, 4'hE, 7'h40, 0, 0);  add(3, 8, 4'hE, 7'h40, 0, 0);
      add(3, 9, 4'hF, 7'h7F, 1, 0);  add(3, 11, 4'hD, 7'h79, 1, 0);
      add(3, 17, 4'hF, 7'h7F, 1, 0); add(3, 20, 4'hF, 7'h7F, 1, 0);
      add(3, 24, 4'hF, 7'h7F, 1, 0); add(3, 27, 4'h7, 7'h30, 1, 0);
      // Scenario 4: enable drop and re-enable with new capture.
      add(4, 13, 4'hD, 7'h79, 1, 0); add(4, 14, 4'hF, 7'h7F, 1, 0);
      add(4, 16, 4'hF, 7'h7F, 1, 0); add(4, 18, 4'hF, 7'h7F, 1, 0);
      add(4, 19, 4'hE, 7'h12, 1, 0);
      // Scenario 5: mid-slot reset.
      add(5, 20, 4'hB, 7'h24, 1, 0); add(5, 21, 4'hF, 7'h7F, 1, 0);
      add(5, 24, 4'hF, 7'h7F, 1, 0); add(5, 25, 4'hE, 7'h40, 1, 0);

      // Reset state.
      std_inputs();
      do_reset();
      chk("reset_dig", int'(o_dig), 4'hF);
      chk("reset_seg", int'(o_seg), 7'h7F);
      chk("reset_dp", int'(o_dp), 1);
      chk("reset_frame", int'(o_frame), 0);

      // Scenario 1+2
      repeat (41) begin
         tick();
         if (ocyc == 5) s0 = 7'h00;
      end
      check_tbl(1);

      // Scenario 3
      std_inputs();
      mask = 4'b0100;
      dp = 4'b0001;
      do_reset();
      repeat (28) tick();
      check_tbl(3);

      // Scenario 4
      std_inputs();
      do_reset();
      repeat (13) tick();
      en = 1'b0;
      repeat (3) tick();
      s0 = 7'h12;
      en = 1'b1;
      repeat (4) tick();
      check_tbl(4);

      // Scenario 5
      std_inputs();
      do_reset();
      repeat (20) tick();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      repeat (4) tick();
      check_tbl(5);

      // Scenario 6: random stimulus against the model.
      std_inputs();
      do_reset();
      repeat (1000) begin
         reset = ($urandom_range(0, 199) == 0);
         en    = ($urandom_range(0, 29) != 0);
         if ($urandom_range(0, 3) == 0) begin
            s0 = 7'($urandom); s1 = 7'($urandom);
            s2 = 7'($urandom); s3 = 7'($urandom);
            dp = 4'($urandom);
            mask = 4'($urandom) & 4'($urandom);
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_7seg_scan.md
# lsu_7seg_scan

Time-multiplexed 7-segment scan driver for the LSU display output path. It sits directly downstream of the LSU nibble-to-segment translator and takes its four active-low segment codes. It drives them onto one shared segment bus with active-low digit enables. Each digit gets a fixed dwell, and each dwell starts with an anti-ghosting blank interval. Inputs are captured once per frame, so a mid-frame store to the display register never tears the displayed value.

## Interface
- DWELL, 50000: cycles per digit slot; legal range 2..2^16-1.
- BLANK, 500: cycles at the start of each slot with all outputs off; legal range 1..DWELL-1. Elaboration fails outside these ranges.
- i_clk  in  1  clock; all state updates on its rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_en  in  1  scan enable; low forces the display dark and restarts the frame.
- i_7seg0..i_7seg3  in  7 each  active-low segment codes, digits 0..3.
- i_dp  in  4  decimal point per digit, active-high.
- i_blank_mask  in  4  bit k=1 forces digit k dark for its whole slot.
- o_seg  out  7  shared segment bus, active-low.
- o_dp  out  1  shared decimal point, active-low.
- o_dig  out  4  digit enables, active-low, at most one low at a time.
- o_frame  out  1  one-cycle pulse marking the last output cycle of digit 3.

## Operation
- State: slot counter `cnt` (0..DWELL-1), digit index `idx` (0..3), phase FSM {BLANK, SHOW}.
- Shadow registers hold four 7-bit codes, 4 dp bits and a 4-bit mask.
- Counter:
  - `cnt` increments each cycle and wraps DWELL-1 -> 0.
  - On wrap, `idx` increments, and 3 -> 0 wraps.
- FSM:
  - BLANK while `cnt` < BLANK.
  - BLANK -> SHOW when `cnt` == BLANK-1.
  - SHOW -> BLANK when `cnt` == DWELL-1.
- Capture: in the cycle with `idx`==0 and `cnt`==0, all of i_7seg0..3, i_dp and i_blank_mask load into the shadow. There is no capture at any other time.
- Outputs are registered and computed each cycle from the current (phase, `idx`, shadow):
  - SHOW and mask[`idx`]==0: o_dig = ~(1<<`idx`), o_seg = shadow code[`idx`], o_dp = ~dp[`idx`].
  - Otherwise: o_dig=4'hF, o_seg=7'h7F, o_dp=1.
- o_frame is registered high for one cycle when `idx`==3 and `cnt`==DWELL-1.
- i_en=0, evaluated each cycle and taking precedence over counting:
  - `cnt`, `idx` <= 0 and phase <= BLANK.
  - Outputs <= dark, o_frame <= 0, and the shadow holds.
  - The first cycle with i_en=1 behaves as frame-start cycle 0, so a capture occurs.
- Reset (synchronous, at any point, including mid-slot):
  - `cnt`=0, `idx`=0, phase=BLANK.
  - Shadow codes=7'h7F, dp=0, mask=4'hF.
  - o_seg=7'h7F, o_dp=1, o_dig=4'hF, o_frame=0.
  - Reset overrides i_en.

## Timing
- Cycle 0 is the first rising edge with i_reset=0 and i_en=1, with `cnt`=0 and `idx`=0. The capture happens at this edge.
- Output latency is 1 cycle after the counter state. With BLANK>=1 the shadow is always valid before the first SHOW.
- Digit k is lit on output cycles k·DWELL+BLANK+1 through (k+1)·DWELL, inclusive.
- Frame length is 4·DWELL cycles. o_frame is high on output cycle 4·DWELL, then again every 4·DWELL cycles.
- Input changes after the capture edge appear only at the next frame's capture.
- At most one o_dig bit is low in any cycle. Between adjacent lit slots there are at least BLANK dark cycles.
- The mask is applied per slot: a masked digit yields a fully dark slot but still consumes its DWELL cycles.

## Structure
- Shared package lsu_pkg holds SEG_OFF=7'h7F, NUM_DIGITS=4 and the phase enum typedef {PH_BLANK, PH_SHOW}.
- One sub-module, lsu_scan_counter, holds the DWELL counter plus digit index. It exposes `cnt`, `idx`, a wrap strobe and a frame-start strobe, with a synchronous clear tied to i_reset | ~i_en.
- The top level holds the FSM, the shadow capture and the registered output mux.

## Test plan
All scenarios use DWELL=8, BLANK=2; "cycle" means output cycle as defined under Timing.
1. Basic scan:
   - Stimulus: reset, then codes 7'h40, 7'h79, 7'h24, 7'h30, dp=0, mask=0.
   - Response: o_dig=4'hE with o_seg=7'h40 on cycles 3-8; 4'hD/7'h79 on cycles 11-16; 4'hB/7'h24 on cycles 19-24; 4'h7/7'h30 on cycles 27-32.
   - Response: o_frame=1 only on cycle 32; dark on cycles 1-2, 9-10, 17-18, 25-26.
2. No tearing: change i_7seg0 to 7'h00 at cycle 5 -> digit 0 still shows 7'h40 through cycle 8, and shows 7'h00 on cycles 35-40.
3. Mask and dp: mask=4'b0100, dp=4'b0001 -> o_dp=0 only on cycles 3-8; o_dig stays 4'hF on cycles 17-24.
4. Enable drop: i_en=0 at cycle 13 -> outputs dark on the next cycle. On re-enable, digit 0 is lit 3 cycles after the first i_en=1 edge.
5. Mid-slot reset: assert i_reset at cycle 20 -> next cycle o_dig=4'hF, o_seg=7'h7F, o_frame=0. The shadow is cleared, so no digit is lit until a new capture.
6. One-hot invariant: random inputs over 1000 cycles -> o_dig is never anything other than 4'hF or a single low bit.
